// File: rtl/hmac_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hmac_req_arbiter : round-robin, message-locking arbiter in front of hmac_core
// Optional lock watchdog: define HMAC_ARB_LOCK_TIMEOUT_EN.        Rev 1.0
// ----------------------------------------------------------------------------
module hmac_req_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    zeroize,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_first,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [NUM_REQ*384-1:0]  req_key,
  input  logic [NUM_REQ*1024-1:0] req_block,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [383:0]            tag_out,
  output logic [NUM_REQ-1:0]      tag_valid_out,
  output logic                    busy,
  output logic [ID_W-1:0]         owner_id,
  output logic                    lock_err,
  output logic                    core_init,
  output logic                    core_next,
  output logic [383:0]            core_key,
  output logic [1023:0]           core_block,
  input  logic                    core_ready,
  input  logic [383:0]            core_tag,
  input  logic                    core_tag_valid
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || ID_W < $clog2(NUM_REQ)) begin : g_param_check
    $error("hmac_req_arbiter: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  state_e              state_q;
  logic                lock_q;
  logic                last_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     owner_q;
  logic [383:0]        key_q;
  logic [1023:0]       block_q;
  logic [383:0]        tag_q;
  logic [NUM_REQ-1:0]  tag_valid_q;
  logic                init_q;
  logic                next_q;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     rr_next_d;

  assign rr_next_d = ID_W'((int'(owner_q) + 1) % NUM_REQ);

  // Unlocked: only message starts compete. Locked: only the owner may proceed.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lock_q) eligible[i] = req_valid[i] && (ID_W'(i) == owner_q);
      else        eligible[i] = req_valid[i] && req_first[i];
    end
    if (state_q != ST_IDLE || !core_ready) eligible = '0;
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign req_ready     = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign tag_out       = tag_q;
  assign tag_valid_out = tag_valid_q;
  assign busy          = (state_q != ST_IDLE) || lock_q;
  assign owner_id      = owner_q;
  assign core_init     = init_q;
  assign core_next     = next_q;
  assign core_key      = key_q;
  assign core_block    = block_q;

`ifdef HMAC_ARB_LOCK_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            lock_err_q;
  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n || zeroize) begin
      state_q     <= ST_IDLE;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      key_q       <= '0;
      block_q     <= '0;
      tag_q       <= '0;
      tag_valid_q <= '0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
`ifdef HMAC_ARB_LOCK_TIMEOUT_EN
      to_cnt_q    <= '0;
      lock_err_q  <= 1'b0;
`endif
    end else begin
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      tag_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            key_q   <= req_key[grant_idx*384 +: 384];
            block_q <= req_block[grant_idx*1024 +: 1024];
            last_q  <= req_last[grant_idx];
            owner_q <= grant_idx;
            init_q  <= req_first[grant_idx];
            next_q  <= !req_first[grant_idx];
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: begin
          if (!core_ready) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (core_ready && core_tag_valid) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // A non-final block keeps the core reserved for the same owner.
          if (last_q) begin
            tag_q       <= core_tag;
            tag_valid_q <= NUM_REQ'(1) << owner_q;
            lock_q      <= 1'b0;
            rr_ptr_q    <= rr_next_d;
          end else begin
            lock_q      <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef HMAC_ARB_LOCK_TIMEOUT_EN
      lock_err_q <= 1'b0;
      if (state_q == ST_IDLE && lock_q && !grant_vld) begin
        if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          to_cnt_q   <= '0;
          lock_q     <= 1'b0;
          rr_ptr_q   <= rr_next_d;
          lock_err_q <= 1'b1;
        end else begin
          to_cnt_q   <= to_cnt_q + 1'b1;
        end
      end else if (grant_vld || !lock_q) begin
        to_cnt_q <= '0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hmac_req_arbiter.sv
`default_nettype none
// Directed bench for hmac_req_arbiter with a simple behavioural hmac_core stand-in.
module tb_hmac_req_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int LAT     = 4;
  localparam logic [383:0]  KAT_KEY = {{20{8'h0b}}, 224'h0};
  localparam logic [1023:0] KAT_BLK = {64'h4869205468657265, 8'h80, 824'h0, 128'h440};
  localparam logic [383:0]  KAT_TAG = 384'hafd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6;

  logic clk = 1'b0;
  logic reset_n, zeroize;
  logic [NUM_REQ-1:0] req_valid, req_first, req_last, req_ready, tag_valid_out;
  logic [NUM_REQ*384-1:0]  req_key;
  logic [NUM_REQ*1024-1:0] req_block;
  logic [383:0]  tag_out, core_key, core_tag;
  logic [1023:0] core_block;
  logic [ID_W-1:0] owner_id;
  logic busy, lock_err, core_init, core_next, core_ready, core_tag_valid;

  hmac_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .req_valid(req_valid), .req_first(req_first), .req_last(req_last),
    .req_key(req_key), .req_block(req_block), .req_ready(req_ready),
    .tag_out(tag_out), .tag_valid_out(tag_valid_out), .busy(busy),
    .owner_id(owner_id), .lock_err(lock_err), .core_init(core_init),
    .core_next(core_next), .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_tag(core_tag), .core_tag_valid(core_tag_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] tagf(input logic [383:0] k, input logic [1023:0] b);
    if (k == KAT_KEY && b == KAT_BLK) return KAT_TAG;
    return k ^ b[383:0] ^ b[1023:640] ^ {b[639:384], 128'h0};
  endfunction

  function automatic logic [383:0] chain(input logic f, input logic [383:0] acc,
                                         input logic [383:0] k, input logic [1023:0] b);
    return f ? tagf(k, b) : ({acc[382:0], acc[383]} ^ tagf(k, b));
  endfunction

  function automatic logic [383:0] mk_key(input int i);
    return {12{32'hA500_0000 | i}};
  endfunction

  function automatic logic [1023:0] mk_blk(input int i);
    return {32{32'h3C00_0000 + i * 7}};
  endfunction

  // Core stand-in: busy for LAT cycles per command, samples key/block at completion.
  int m_cnt;
  logic m_first;
  logic [383:0] m_acc;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_tag_valid <= 1'b0; core_tag <= '0;
      m_cnt <= 0; m_first <= 1'b0; m_acc <= '0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0; core_tag_valid <= 1'b0; m_cnt <= LAT; m_first <= core_init;
    end else if (!core_ready) begin
      if (m_cnt == 1) begin
        core_ready     <= 1'b1;
        core_tag_valid <= 1'b1;
        core_tag       <= chain(m_first, m_acc, core_key, core_block);
        m_acc          <= chain(m_first, m_acc, core_key, core_block);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    int r; bit first; bit last; logic [383:0] key; logic [1023:0] blk;
    bit exp_grant; bit exp_pulse; bit exp_lock;
  } vec_t;

  int n_chk, n_fail;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit f, input bit l,
                         input logic [383:0] k, input logic [1023:0] b);
    req_valid[r] = v; req_first[r] = f; req_last[r] = l;
    req_key[r*384 +: 384] = k; req_block[r*1024 +: 1024] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; zeroize = 1'b0;
    req_valid = '0; req_first = '0; req_last = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns one cycle after the grant edge (ISSUE cycle), sampled #1 past negedge.
  task automatic send(input vec_t v, input int budget, output bit granted);
    @(negedge clk);
    set_req(v.r, 1'b1, v.first, v.last, v.key, v.blk);
    granted = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (req_ready[v.r]) begin granted = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[v.r] = 1'b0;
    #1;
  endtask

  task automatic watch(input string nm, input int cycles, input int r,
                       input logic [383:0] exp_tag, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (tag_valid_out != '0) begin
        pulses++;
        chk({nm, "_tvo"}, tag_valid_out, NUM_REQ'(1) << r);
        chk({nm, "_tag"}, tag_out, exp_tag);
      end
    end
  endtask

  function automatic vec_t mkv(input int r, input bit f, input bit l, input int ki,
                               input bit g, input bit p, input bit lk);
    vec_t v;
    v.r = r; v.first = f; v.last = l;
    v.key = (ki == 0) ? KAT_KEY : mk_key(ki);
    v.blk = (ki == 0) ? KAT_BLK : mk_blk(ki);
    v.exp_grant = g; v.exp_pulse = p; v.exp_lock = lk;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  vec_t vt[7];
  vec_t v;
  bit granted, adv;
  int pulses, g, p, n1, ninit, nnext, pc, r0c, seen;
  logic [383:0] exp_acc, e;

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; zeroize = 1'b0;
    req_valid = '0; req_first = '0; req_last = '0; req_key = '0; req_block = '0;
    exp_acc = '0;

    //            r  f  l  key g  pulse lock
    vt[0] = mkv(0, 1, 1, 0, 1, 1, 0);   // RFC 4231 single block
    vt[1] = mkv(1, 1, 1, 1, 1, 1, 0);
    vt[2] = mkv(0, 1, 0, 2, 1, 0, 1);   // opens a locked message
    vt[3] = mkv(0, 0, 1, 3, 1, 1, 0);   // continuation closes it
    vt[4] = mkv(1, 1, 0, 4, 1, 0, 1);
    vt[5] = mkv(1, 1, 1, 5, 1, 1, 0);   // owner restarts with init while locked
    vt[6] = mkv(0, 0, 1, 6, 0, 0, 0);   // continuation while unlocked is ignored

    do_reset();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_tvo", tag_valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_key", core_key, 0);
    chk("rst_cmd", {core_init, core_next}, 0);
    chk("rst_lockerr", lock_err, 0);

    for (int i = 0; i < 7; i++) begin
      send(vt[i], 12, granted);
      chk($sformatf("v%0d_grant", i), granted, vt[i].exp_grant);
      if (granted) begin
        chk($sformatf("v%0d_owner", i), owner_id, vt[i].r);
        chk($sformatf("v%0d_init", i), core_init, vt[i].first);
        chk($sformatf("v%0d_next", i), core_next, !vt[i].first);
        chk($sformatf("v%0d_key", i), core_key, vt[i].key);
        exp_acc = chain(vt[i].first, exp_acc, vt[i].key, vt[i].blk);
      end
      watch($sformatf("v%0d", i), LAT + 6, vt[i].r, exp_acc, pulses);
      chk($sformatf("v%0d_npulse", i), pulses, vt[i].exp_pulse);
      chk($sformatf("v%0d_lock", i), busy, vt[i].exp_lock);
    end

    // Inputs churn after the grant; the captured key/block must not move.
    v = mkv(0, 1, 1, 7, 1, 1, 0);
    send(v, 12, granted);
    chk("st_grant", granted, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_key[383:0] = {12{$urandom()}};
      req_block[1023:0] = {32{$urandom()}};
      #1;
      if (tag_valid_out != '0) begin
        chk("st_tag", tag_out, tagf(v.key, v.blk));
        seen = 1;
        break;
      end
      chk($sformatf("st_key%0d", c), core_key, v.key);
      chk($sformatf("st_blk%0d", c), core_block == v.blk, 1);
    end
    chk("st_seen", seen, 1);
    repeat (3) @(negedge clk);

    // Zeroize while waiting on the core.
    chk("zz_pre_tag", tag_out, tagf(v.key, v.blk));
    v = mkv(0, 1, 1, 8, 1, 1, 0);
    send(v, 12, granted);
    chk("zz_grant", granted, 1);
    @(negedge clk);
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    chk("zz_tag", tag_out, 0);
    chk("zz_busy", busy, 0);
    chk("zz_key", core_key, 0);
    chk("zz_owner", owner_id, 0);
    watch("zz_quiet", 12, 0, 0, pulses);
    chk("zz_npulse", pulses, 0);
    v = mkv(1, 1, 1, 9, 1, 1, 0);
    send(v, 30, granted);
    chk("zz_after_grant", granted, 1);
    watch("zz_after", LAT + 6, 1, tagf(v.key, v.blk), pulses);
    chk("zz_after_npulse", pulses, 1);

    // Round robin with both requesters streaming single blocks.
    do_reset();
    set_req(0, 1, 1, 1, mk_key(10), mk_blk(10));
    set_req(1, 1, 1, 1, mk_key(11), mk_blk(11));
    g = 0; p = 0;
    for (int c = 0; c < 120 && p < 4; c++) begin
      #1;
      if (req_ready != '0 && g < 4) begin
        chk($sformatf("rr_grant%0d", g), req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
        g++;
      end
      if (tag_valid_out != '0) begin
        chk($sformatf("rr_pulse%0d", p), tag_valid_out, (p % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("rr_tag%0d", p), tag_out,
            (p % 2 == 0) ? tagf(mk_key(10), mk_blk(10)) : tagf(mk_key(11), mk_blk(11)));
        p++;
      end
      @(negedge clk);
    end
    chk("rr_npulse", p, 4);
    req_valid = '0;

    // Lock: requester 1 holds the core for three blocks while requester 0 waits.
    do_reset();
    v = mkv(0, 1, 1, 12, 1, 1, 0);
    send(v, 12, granted);
    chk("lk_pre_grant", granted, 1);
    repeat (LAT + 6) @(negedge clk);
    set_req(0, 1, 1, 1, mk_key(13), mk_blk(13));
    set_req(1, 1, 1, 0, mk_key(14), mk_blk(14));
    n1 = 0; adv = 0; ninit = 0; nnext = 0; pc = -1; r0c = -2;
    for (int c = 0; c < 150; c++) begin
      if (adv) begin
        adv = 0;
        if (n1 < 3) set_req(1, 1, n1 == 0, n1 == 2, mk_key(14 + n1), mk_blk(14 + n1));
        else req_valid[1] = 1'b0;
      end
      #1;
      if (core_init) ninit++;
      if (core_next) nnext++;
      if (tag_valid_out != '0) begin
        pc = c;
        chk("lk_pulse", tag_valid_out, 2'b10);
      end
      if (req_ready[0]) begin r0c = c; break; end
      if (req_ready[1]) begin n1++; adv = 1; end
      @(negedge clk);
    end
    e = chain(1'b1, '0, mk_key(14), mk_blk(14));
    e = chain(1'b0, e, mk_key(15), mk_blk(15));
    e = chain(1'b0, e, mk_key(16), mk_blk(16));
    chk("lk_tag", tag_out, e);
    chk("lk_n1", n1, 3);
    chk("lk_ninit", ninit, 1);
    chk("lk_nnext", nnext, 2);
    chk("lk_r0_cycle", r0c, pc);
    req_valid = '0;
    repeat (LAT + 6) @(negedge clk);

`ifdef HMAC_ARB_LOCK_TIMEOUT_EN
    do_reset();
    v = mkv(0, 1, 0, 18, 1, 0, 1);
    send(v, 12, granted);
    chk("to_grant", granted, 1);
    set_req(1, 1, 1, 1, mk_key(19), mk_blk(19));
    pc = -1; r0c = -2;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (lock_err && pc < 0) pc = c;
      if (req_ready[1]) begin r0c = c; break; end
      @(negedge clk);
    end
    chk("to_lockerr_seen", pc >= 0, 1);
    chk("to_r1_cycle", r0c, pc);
    req_valid = '0;
    repeat (LAT + 6) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
